// File: rtl/bcd_scan_display_pkg.sv
// -----------------------------------------------------------------------------
// bcd_scan_display_pkg
// Shared constants for the multiplexed 7-segment time display:
//   - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - digit index constants (index 0 is the leftmost digit, HourH)
//   - NUM_DIGITS, the number of scanned digits
// -----------------------------------------------------------------------------
package bcd_scan_display_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns, active-low, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Digit positions, left to right
    localparam logic [2:0] DIG_HH = 3'd0;
    localparam logic [2:0] DIG_HL = 3'd1;
    localparam logic [2:0] DIG_MH = 3'd2;
    localparam logic [2:0] DIG_ML = 3'd3;
    localparam logic [2:0] DIG_SH = 3'd4;
    localparam logic [2:0] DIG_SL = 3'd5;

endpackage

// File: rtl/bcd_scan_display_bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Pure combinational BCD to 7-segment decoder, active-low outputs.
// Codes 10..15 are not valid BCD and are shown as a dash (segment g only).
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Time-multiplexed driver for a 6-digit common-anode 7-segment display showing
// HH:MM:SS. Each digit is lit for SCAN_DIV clocks; the six BCD inputs and PM
// are snapshotted once per frame so a digit never changes mid-frame. Digits
// selected by BlinkMask are blanked during alternate BLINK_DIV-frame windows.
//
// Ports:
//   CP        in  1  clock
//   CR        in  1  synchronous active-high reset
//   EN        in  1  scan enable; low holds the scan state and blanks outputs
//   HourH..SecL in 4 each  BCD digits (index 0 = HourH ... index 5 = SecL)
//   PM        in  1  PM indicator, shown on the DP of digit 5
//   BlinkMask in  6  per-digit blink enable, sampled live
//   Seg       out 7  segments {g,f,e,d,c,b,a}, active-low, registered
//   DP        out 1  decimal point, active-low, registered
//   AN        out 6  digit enables, active-low, registered
//   FrameDone out 1  one-cycle pulse when digit 5 finishes its slot
//
// Optional feature: define BCD_SCAN_LZB_EN for leading-zero blanking of HourH.
// -----------------------------------------------------------------------------
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
)(
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic [3:0] HourH,
    input  logic [3:0] HourL,
    input  logic [3:0] MinH,
    input  logic [3:0] MinL,
    input  logic [3:0] SecH,
    input  logic [3:0] SecL,
    input  logic       PM,
    input  logic [5:0] BlinkMask,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [5:0] AN,
    output logic       FrameDone
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    idx_reg, idx_next;
    logic [FW-1:0] frame_reg, frame_next;
    logic          phase_reg, phase_next;
    logic          cap_pending_reg, cap_pending_next;
    logic [3:0]    shadow_reg [NUM_DIGITS];
    logic          pm_reg;
    logic [3:0]    digit_in [NUM_DIGITS];

    logic          tick;
    logic          frame_end;
    logic          capture;
    logic [3:0]    cur_digit;
    logic          cur_blink;
    logic [6:0]    dec_seg;
    logic          lzb_blank;

    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic [5:0]    an_reg, an_next;
    logic          fd_reg, fd_next;

    assign digit_in[0] = HourH;
    assign digit_in[1] = HourL;
    assign digit_in[2] = MinH;
    assign digit_in[3] = MinL;
    assign digit_in[4] = SecH;
    assign digit_in[5] = SecL;

    // ---------------- scan sequencing ----------------
    always_comb begin
        tick      = EN && (presc_reg == PW'(SCAN_DIV - 1));
        frame_end = tick && (idx_reg == DIG_SL);
        // A pending capture covers the first enabled cycle after reset so the
        // shadow does not show zeros for a whole frame.
        capture   = EN && (cap_pending_reg || frame_end);

        presc_next       = presc_reg;
        idx_next         = idx_reg;
        frame_next       = frame_reg;
        phase_next       = phase_reg;
        cap_pending_next = cap_pending_reg && !EN;

        if (EN) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end
        if (tick) begin
            idx_next = (idx_reg == DIG_SL) ? DIG_HH : idx_reg + 3'd1;
        end
        if (frame_end) begin
            if (frame_reg == FW'(BLINK_DIV - 1)) begin
                frame_next = '0;
                phase_next = ~phase_reg;
            end else begin
                frame_next = frame_reg + FW'(1);
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            presc_reg       <= '0;
            idx_reg         <= DIG_HH;
            frame_reg       <= '0;
            phase_reg       <= 1'b0;
            cap_pending_reg <= 1'b1;
            pm_reg          <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i] <= 4'd0;
            end
        end else begin
            presc_reg       <= presc_next;
            idx_reg         <= idx_next;
            frame_reg       <= frame_next;
            phase_reg       <= phase_next;
            cap_pending_reg <= cap_pending_next;
            if (capture) begin
                pm_reg <= PM;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow_reg[i] <= digit_in[i];
                end
            end
        end
    end

    // ---------------- digit selection and decode ----------------
    // Explicit compare loops keep the selects safe for idx values 6 and 7.
    always_comb begin
        cur_digit = 4'd0;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == 3'(i)) begin
                cur_digit = shadow_reg[i];
                cur_blink = BlinkMask[i];
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef BCD_SCAN_LZB_EN
    assign lzb_blank = (idx_reg == DIG_HH) && (shadow_reg[0] == 4'd0);
`else
    assign lzb_blank = 1'b0;
`endif

    // ---------------- output stage ----------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_next[gi] = ~(EN && (idx_reg == 3'(gi)));
        end
    endgenerate

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        fd_next  = frame_end;
        if (EN) begin
            if (phase_reg && cur_blink) begin
                seg_next = SEG_OFF;
                dp_next  = 1'b1;
            end else begin
                seg_next = lzb_blank ? SEG_OFF : dec_seg;
                // Colons after the hour and minute pairs; PM dot on the last digit.
                dp_next  = !((idx_reg == DIG_HL) || (idx_reg == DIG_ML) ||
                             ((idx_reg == DIG_SL) && pm_reg));
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= 1'b1;
            an_reg  <= 6'b111111;
            fd_reg  <= 1'b0;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
            fd_reg  <= fd_next;
        end
    end

    assign Seg       = seg_reg;
    assign DP        = dp_reg;
    assign AN        = an_reg;
    assign FrameDone = fd_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Directed self-checking bench for bcd_scan_display with SCAN_DIV=4,
// BLINK_DIV=2. Inputs change and outputs are sampled 1 time unit after the
// rising edge. Frame edges are counted in fd_count; blink phase is 1 during
// the frames following FrameDone number 2,3, 6,7, ...
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    logic       CP;
    logic       CR;
    logic       EN;
    logic [3:0] HourH, HourL, MinH, MinL, SecH, SecL;
    logic       PM;
    logic [5:0] BlinkMask;
    logic [6:0] Seg;
    logic       DP;
    logic [5:0] AN;
    logic       FrameDone;

    int errors;
    int checks;
    int fd_count;

    bcd_scan_display #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .CP        (CP),
        .CR        (CR),
        .EN        (EN),
        .HourH     (HourH),
        .HourL     (HourL),
        .MinH      (MinH),
        .MinL      (MinL),
        .SecH      (SecH),
        .SecL      (SecL),
        .PM        (PM),
        .BlinkMask (BlinkMask),
        .Seg       (Seg),
        .DP        (DP),
        .AN        (AN),
        .FrameDone (FrameDone)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    // Advance to the next FrameDone pulse, bounded.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (FrameDone !== 1'b1 && n < 100);
        checks++;
        if (FrameDone !== 1'b1) begin
            errors++;
            $display("FAIL frame_timeout: FrameDone=%b after %0d cycles, required 1", FrameDone, n);
        end
        fd_count++;
    endtask

    task automatic test_reset();
        CR = 1'b1; EN = 1'b1;
        step(2);
        checks++;
        if (AN !== 6'b111111) begin errors++; $display("FAIL reset_an: got %b required 111111", AN); end
        checks++;
        if (Seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b required 1111111", Seg); end
        checks++;
        if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", DP); end
        checks++;
        if (FrameDone !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", FrameDone); end
        $display("reset: AN=%b Seg=%b DP=%b FD=%b", AN, Seg, DP, FrameDone);
        CR = 1'b0;
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [6];
        logic [5:0] exp_an;
        logic       exp_dp;
        int n;
        exp_seg = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
        step(2);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step(4);
            exp_an = ~(6'b000001 << k);
            exp_dp = (k == 1 || k == 3) ? 1'b0 : 1'b1;
            $display("scan slot%0d: AN=%b Seg=%b DP=%b", k, AN, Seg, DP);
            checks++;
            if (AN !== exp_an) begin errors++; $display("FAIL scan_an slot%0d: got %b required %b", k, AN, exp_an); end
            checks++;
            if (Seg !== exp_seg[k]) begin errors++; $display("FAIL scan_seg slot%0d: got %b required %b", k, Seg, exp_seg[k]); end
            checks++;
            if (DP !== exp_dp) begin errors++; $display("FAIL scan_dp slot%0d: got %b required %b", k, DP, exp_dp); end
        end
        step(2);
        checks++;
        if (FrameDone !== 1'b1) begin errors++; $display("FAIL scan_fd_first: got %b required 1", FrameDone); end
        fd_count++;
        step(1);
        checks++;
        if (FrameDone !== 1'b0) begin errors++; $display("FAIL scan_fd_width: got %b required 0", FrameDone); end
        wait_frame(n);
        n = n + 1;
        $display("scan frame period: %0d cycles", n);
        checks++;
        if (n !== 24) begin errors++; $display("FAIL scan_fd_period: got %0d required 24", n); end
    endtask

    task automatic test_shadow();
        int n;
        step(6);
        MinL = 4'd7;
        step(8);
        $display("shadow same frame: Seg=%b", Seg);
        checks++;
        if (Seg !== 7'b0011001) begin errors++; $display("FAIL shadow_hold: got %b required 0011001", Seg); end
        wait_frame(n);
        step(14);
        $display("shadow next frame: AN=%b Seg=%b", AN, Seg);
        checks++;
        if (Seg !== 7'b1111000) begin errors++; $display("FAIL shadow_update: got %b required 1111000", Seg); end
        checks++;
        if (AN !== 6'b110111) begin errors++; $display("FAIL shadow_an: got %b required 110111", AN); end
    endtask

    task automatic test_invalid();
        int n;
        HourL = 4'hC;
        wait_frame(n);
        step(6);
        $display("invalid: Seg=%b DP=%b", Seg, DP);
        checks++;
        if (Seg !== 7'b0111111) begin errors++; $display("FAIL invalid_seg: got %b required 0111111", Seg); end
        checks++;
        if (DP !== 1'b0) begin errors++; $display("FAIL invalid_dp: got %b required 0", DP); end
        HourL = 4'd2;
    endtask

    task automatic test_pm();
        int n;
        PM = 1'b1;
        wait_frame(n);
        step(14);
        checks++;
        if (DP !== 1'b0) begin errors++; $display("FAIL pm_dp3: got %b required 0", DP); end
        step(4);
        checks++;
        if (DP !== 1'b1) begin errors++; $display("FAIL pm_dp4: got %b required 1", DP); end
        step(4);
        $display("pm=1 slot5: DP=%b", DP);
        checks++;
        if (DP !== 1'b0) begin errors++; $display("FAIL pm_dp5_on: got %b required 0", DP); end
        PM = 1'b0;
        wait_frame(n);
        step(22);
        $display("pm=0 slot5: DP=%b", DP);
        checks++;
        if (DP !== 1'b1) begin errors++; $display("FAIL pm_dp5_off: got %b required 1", DP); end
    endtask

    task automatic test_blink();
        int n;
        BlinkMask = 6'b000011;
        wait_frame(n);  // seventh frame edge: blink phase 1
        step(2);
        $display("blink on slot0: AN=%b Seg=%b DP=%b", AN, Seg, DP);
        checks++;
        if (AN !== 6'b111110) begin errors++; $display("FAIL blink_an0: got %b required 111110", AN); end
        checks++;
        if (Seg !== 7'h7F) begin errors++; $display("FAIL blink_seg0: got %b required 1111111", Seg); end
        step(4);
        checks++;
        if (Seg !== 7'h7F) begin errors++; $display("FAIL blink_seg1: got %b required 1111111", Seg); end
        checks++;
        if (DP !== 1'b1) begin errors++; $display("FAIL blink_dp1: got %b required 1", DP); end
        step(4);
        checks++;
        if (Seg !== 7'b0110000) begin errors++; $display("FAIL blink_seg2: got %b required 0110000", Seg); end
        wait_frame(n);  // eighth frame edge: blink phase 0
        step(2);
        $display("blink off slot0: Seg=%b", Seg);
        checks++;
        if (Seg !== 7'b1111001) begin errors++; $display("FAIL blink_off_seg0: got %b required 1111001", Seg); end
        step(4);
        checks++;
        if (Seg !== 7'b0100100) begin errors++; $display("FAIL blink_off_seg1: got %b required 0100100", Seg); end
        checks++;
        if (DP !== 1'b0) begin errors++; $display("FAIL blink_off_dp1: got %b required 0", DP); end
        BlinkMask = 6'b000000;
    endtask

    task automatic test_lzb();
        int n;
        logic [6:0] exp_seg;
`ifdef BCD_SCAN_LZB_EN
        exp_seg = 7'h7F;
`else
        exp_seg = 7'b1000000;
`endif
        HourH = 4'd0;
        wait_frame(n);
        step(2);
        $display("hourh=0 slot0: AN=%b Seg=%b DP=%b", AN, Seg, DP);
        checks++;
        if (Seg !== exp_seg) begin errors++; $display("FAIL lzb_seg: got %b required %b", Seg, exp_seg); end
        checks++;
        if (AN !== 6'b111110) begin errors++; $display("FAIL lzb_an: got %b required 111110", AN); end
        HourH = 4'd1;
    endtask

    task automatic test_enable();
        int n;
        wait_frame(n);
        step(10);
        EN = 1'b0;
        step(1);
        $display("en=0: AN=%b Seg=%b DP=%b", AN, Seg, DP);
        checks++;
        if (AN !== 6'b111111) begin errors++; $display("FAIL en_off_an: got %b required 111111", AN); end
        checks++;
        if (Seg !== 7'h7F) begin errors++; $display("FAIL en_off_seg: got %b required 1111111", Seg); end
        step(10);
        checks++;
        if (AN !== 6'b111111 || FrameDone !== 1'b0) begin
            errors++; $display("FAIL en_off_hold: got AN=%b FD=%b required 111111/0", AN, FrameDone);
        end
        EN = 1'b1;
        step(1);
        $display("en=1 resume: AN=%b Seg=%b", AN, Seg);
        checks++;
        if (AN !== 6'b111011) begin errors++; $display("FAIL en_resume_an: got %b required 111011", AN); end
        checks++;
        if (Seg !== 7'b0110000) begin errors++; $display("FAIL en_resume_seg: got %b required 0110000", Seg); end
        step(1);
        checks++;
        if (AN !== 6'b111011) begin errors++; $display("FAIL en_resume_presc: got %b required 111011", AN); end
        step(1);
        checks++;
        if (AN !== 6'b110111) begin errors++; $display("FAIL en_resume_next_an: got %b required 110111", AN); end
        checks++;
        if (Seg !== 7'b1111000) begin errors++; $display("FAIL en_resume_next_seg: got %b required 1111000", Seg); end
    endtask

    task automatic test_reset_mid();
        step(3);
        CR = 1'b1;
        step(1);
        $display("mid reset: AN=%b Seg=%b DP=%b FD=%b", AN, Seg, DP, FrameDone);
        checks++;
        if (AN !== 6'b111111 || Seg !== 7'h7F || DP !== 1'b1 || FrameDone !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got AN=%b Seg=%b DP=%b FD=%b required 111111/1111111/1/0",
                     AN, Seg, DP, FrameDone);
        end
        CR = 1'b0;
        step(1);
        checks++;
        if (AN !== 6'b111110) begin errors++; $display("FAIL mid_reset_idx0: got %b required 111110", AN); end
        step(1);
        checks++;
        if (Seg !== 7'b1111001) begin errors++; $display("FAIL mid_reset_capture: got %b required 1111001", Seg); end
        step(2);
        checks++;
        if (AN !== 6'b111110) begin errors++; $display("FAIL mid_reset_slot_len: got %b required 111110", AN); end
        step(1);
        checks++;
        if (AN !== 6'b111101) begin errors++; $display("FAIL mid_reset_advance: got %b required 111101", AN); end
    endtask

    initial begin
        errors = 0; checks = 0; fd_count = 0;
        CR = 1'b1; EN = 1'b0;
        HourH = 4'd1; HourL = 4'd2; MinH = 4'd3; MinL = 4'd4; SecH = 4'd5; SecL = 4'd6;
        PM = 1'b0; BlinkMask = 6'b000000;
        test_reset();
        test_scan();
        test_shadow();
        test_invalid();
        test_pm();
        test_blink();
        test_lzb();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumer of the BCD time counters: reads six BCD digits (HH:MM:SS) plus the PM/12-hour flag and drives a time-multiplexed 6-digit common-anode 7-segment display.
- Contains a refresh prescaler, a digit-select ring, a per-frame input snapshot so a digit never tears mid-frame, per-digit blink, and invalid-code handling.
- Sits between the counter chain and the board display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is lit (must be >= 2).
- BLINK_DIV, 25, frames per blink half-period (must be >= 1).

Ports:
- CP  in  1  system clock.
- CR  in  1  synchronous active-high reset.
- EN  in  1  scan enable; low freezes the scan and blanks the display.
- HourH, HourL, MinH, MinL, SecH, SecL  in  4 each  BCD digits from the counters.
- PM  in  1  12-hour PM indicator.
- BlinkMask  in  6  bit i set = digit i blinks.
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- AN  out  6  digit enables, active-low; AN[i] drives digit i.
- FrameDone  out  1  one-cycle pulse when digit 5 finishes its slot.

Behaviour:
- Interface: one clock CP; reset CR is synchronous and active-high. All outputs are registered.
- Reset (CR=1 at a CP edge):
  - prescaler=0, index=0, blink phase=0, frame counter=0, shadow digits=0.
  - AN=6'b111111, Seg=7'h7F, DP=1, FrameDone=0.
  - CR overrides EN at the same edge.
- Prescaler counts 0..SCAN_DIV-1 while EN=1. A tick occurs when it reaches SCAN_DIV-1; the prescaler then wraps to 0.
- Digit index 0..5; index 0 = HourH (leftmost), index 5 = SecL.
  - Each tick advances the index; 5 wraps to 0.
  - On the 5->0 wrap: FrameDone=1 for exactly one cycle, and all six inputs plus PM are captured into shadow registers at that edge.
  - Shadow capture also happens on the first enabled cycle after reset.
- Outputs always reflect the current index and the shadow values, with one cycle of latency from the index register.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10-15 display a dash, 0111111.
- DP: lit (0) on index 1 and index 3 (colon separators); lit on index 5 iff shadow PM=1; otherwise 1.
- Blink:
  - The frame counter counts completed frames 0..BLINK_DIV-1; on wrap, blink phase toggles.
  - When phase=1 and BlinkMask[index]=1: AN stays active, Seg=7'h7F, DP=1.
  - BlinkMask is sampled live, not snapshotted.
- EN=0:
  - prescaler, index, frame counter and phase hold.
  - AN=6'b111111, Seg=7'h7F, DP=1, FrameDone=0 from the next cycle.
  - On EN returning to 1, scanning resumes from the held index and prescaler value.
- Exactly one AN bit is low at any time while EN=1 after reset.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN.
- Defined: leading-zero blanking. When shadow HourH==0, index 0 shows Seg=7'h7F with AN still active; its DP is unaffected.
- Undefined: HourH=0 displays "0" normally.

Decomposition:
- Shared package: segment encoding constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF), digit index constants (DIG_HH..DIG_SL), NUM_DIGITS=6.
- One natural sub-module: bcd_to_seg, a pure combinational 4-bit BCD to 7-bit active-low decoder including dash for invalid codes. It is reusable by other display blocks.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
- Reset then EN=1, digits 1,2,3,4,5,6 -> AN walks 011111? no: AN[0] low first, then AN[1]..AN[5], each lit for 4 cycles; Seg sequence 1111001,0100100,0110000,0011001,0010010,0000010; FrameDone pulses every 24 cycles.
- Change MinL from 4 to 7 while index=1 -> digit 3 still shows 4 this frame; shows 7 (1111000) after the next FrameDone.
- HourL=4'hC -> index 1 Seg=0111111, DP=0.
- PM=1 -> DP=0 at index 5 only (plus indices 1 and 3); PM=0 -> DP=1 at index 5.
- BlinkMask=6'b000011 -> digits 0-1 show 7'h7F during alternate 2-frame windows; other digits unaffected.
- EN=0 mid-slot -> AN=111111 next cycle and index held; CR=1 with EN=1 -> all outputs at reset values next cycle, index 0. With BCD_SCAN_LZB_EN defined and HourH=0 -> index 0 Seg=7'h7F.
